cp0_regfile: RTL and testbench

Coprocessor-0 register file and exception-commit unit at the write-back end of the pipeline. Consumes the CP0 fields registered by the MEM/WB stage register. Commits exceptions, ERET and MTC0 writes; serves MFC0 reads. Produces the pipeline flush pulse, the redirect PC, and the pending-interrupt flag used to tag instructions in decode.

---
 rtl/cp0_pkg.sv | 36 +++
 rtl/cp0_regfile_if.sv | 21 ++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_regfile.sv | 131 +++++++++++++
 tb/tb_cp0_regfile.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, field positions, reset values.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } excode_e;

    localparam int unsigned STATUS_BEV   = 22;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_EXC_LO = 2;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// MEM/WB -> CP0 commit bundle; the pipeline drives master, cp0_regfile consumes slave.
interface cp0_regfile_if;
    logic [31:0] wb_pc;
    logic        wb_cp0_ex;
    logic [4:0]  wb_cp0_excode;
    logic [31:0] wb_cp0_badvaddr;
    logic        wb_cp0_bd;
    logic        wb_cp0_we;
    logic [4:0]  wb_cp0_addr;
    logic [31:0] wb_cp0_wdata;
    logic        wb_cp0_eret_flush;

    modport master (
        output wb_pc, wb_cp0_ex, wb_cp0_excode, wb_cp0_badvaddr, wb_cp0_bd,
               wb_cp0_we, wb_cp0_addr, wb_cp0_wdata, wb_cp0_eret_flush
    );
    modport slave (
        input  wb_pc, wb_cp0_ex, wb_cp0_excode, wb_cp0_badvaddr, wb_cp0_bd,
               wb_cp0_we, wb_cp0_addr, wb_cp0_wdata, wb_cp0_eret_flush
    );
endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every COUNT_DIV clocks, TI latches on match.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int unsigned     DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             tick;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            compare <= '0;
            div     <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div   <= '0;
            end else begin
                div <= tick ? '0 : div + DIV_W'(1);
                if (tick)
                    count <= count + 32'd1;
            end
            if (compare_we)
                compare <= wdata;
            // A Compare write acknowledges the interrupt even if it coincides with a match.
            if (compare_we)
                ti <= 1'b0;
            else if (count == compare)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file and exception/ERET/MTC0 commit at write-back.
// Optional timer (Count/Compare/TI) enabled by defining CP0_TIMER_EN.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic               clk,
    input  logic               resetn,
    cp0_regfile_if.slave       wb,
    input  logic [5:0]         ext_int,
    input  logic [4:0]         cp0_raddr,
    output logic [31:0]        cp0_rdata,
    output logic               int_flush,
    output logic [31:0]        int_pc,
    output logic               has_int
);

    if ((COUNT_DIV == 0) || ((COUNT_DIV & (COUNT_DIV - 1)) != 0)) begin : g_div_check
        $error("cp0_regfile: COUNT_DIV must be a power of two");
    end

    logic [31:0] badvaddr;
    logic [31:0] epc;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_excode;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        mtc0_commit;

    logic [31:0] status_word;
    logic [31:0] cause_word;

    assign mtc0_commit = wb.wb_cp0_we & ~wb.wb_cp0_ex & ~wb.wb_cp0_eret_flush;

`ifdef CP0_TIMER_EN
    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (mtc0_commit && (wb.wb_cp0_addr == CP0_COUNT)),
        .compare_we (mtc0_commit && (wb.wb_cp0_addr == CP0_COMPARE)),
        .wdata      (wb.wb_cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            badvaddr     <= '0;
            epc          <= '0;
            status_im    <= '0;
            status_exl   <= 1'b0;
            status_ie    <= 1'b0;
            cause_bd     <= 1'b0;
            cause_ip_hw  <= '0;
            cause_ip_sw  <= '0;
            cause_excode <= '0;
        end else begin
            cause_ip_hw <= {ext_int[5] | ti, ext_int[4:0]};
            if (wb.wb_cp0_ex) begin
                // A nested exception keeps the original return point.
                if (!status_exl) begin
                    epc      <= wb.wb_cp0_bd ? wb.wb_pc - 32'd4 : wb.wb_pc;
                    cause_bd <= wb.wb_cp0_bd;
                end
                status_exl   <= 1'b1;
                cause_excode <= wb.wb_cp0_excode;
                if (is_addr_exc(wb.wb_cp0_excode))
                    badvaddr <= wb.wb_cp0_badvaddr;
            end else if (wb.wb_cp0_eret_flush) begin
                status_exl <= 1'b0;
            end else if (wb.wb_cp0_we) begin
                case (wb.wb_cp0_addr)
                    CP0_STATUS: begin
                        status_im  <= wb.wb_cp0_wdata[STATUS_IM_LO +: 8];
                        status_exl <= wb.wb_cp0_wdata[STATUS_EXL];
                        status_ie  <= wb.wb_cp0_wdata[STATUS_IE];
                    end
                    CP0_CAUSE: cause_ip_sw <= wb.wb_cp0_wdata[CAUSE_IP_LO +: 2];
                    CP0_EPC:   epc         <= wb.wb_cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        status_word                     = STATUS_RESET;
        status_word[STATUS_IM_LO +: 8]  = status_im;
        status_word[STATUS_EXL]         = status_exl;
        status_word[STATUS_IE]          = status_ie;

        cause_word                      = '0;
        cause_word[CAUSE_BD]            = cause_bd;
        cause_word[CAUSE_TI]            = ti;
        cause_word[CAUSE_IP_LO +: 8]    = {cause_ip_hw, cause_ip_sw};
        cause_word[CAUSE_EXC_LO +: 5]   = cause_excode;

        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status_word;
            CP0_CAUSE:    cp0_rdata = cause_word;
            CP0_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = '0;
        endcase
    end

    assign int_flush = wb.wb_cp0_ex | wb.wb_cp0_eret_flush;
    assign int_pc    = wb.wb_cp0_ex ? EXC_ENTRY : epc;
    assign has_int   = (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed-vector bench for cp0_regfile; timer checks follow CP0_TIMER_EN.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  ext_int;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        int_flush;
    logic [31:0] int_pc;
    logic        has_int;

    int unsigned checks = 0;
    int unsigned failures = 0;

    cp0_regfile_if wbif ();

    cp0_regfile #(
        .EXC_ENTRY (32'hBFC0_0380),
        .COUNT_DIV (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .wb        (wbif),
        .ext_int   (ext_int),
        .cp0_raddr (cp0_raddr),
        .cp0_rdata (cp0_rdata),
        .int_flush (int_flush),
        .int_pc    (int_pc),
        .has_int   (has_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ex;
        logic [4:0]  exc;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] badv;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        eret;
        logic [5:0]  ext;
        logic [4:0]  ra;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [31:0] e_rdata;
        logic        e_has;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(input logic ex, input logic [4:0] exc, input logic bd,
                                input logic [31:0] pc, input logic [31:0] badv,
                                input logic we, input logic [4:0] addr, input logic [31:0] wd,
                                input logic eret, input logic [5:0] ext, input logic [4:0] ra,
                                input logic ef, input logic [31:0] epc, input logic [31:0] erd,
                                input logic eh);
        row_t r;
        r.ex = ex; r.exc = exc; r.bd = bd; r.pc = pc; r.badv = badv;
        r.we = we; r.addr = addr; r.wd = wd; r.eret = eret; r.ext = ext; r.ra = ra;
        r.e_flush = ef; r.e_pc = epc; r.e_rdata = erd; r.e_has = eh;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wbif.wb_pc = '0; wbif.wb_cp0_ex = 1'b0; wbif.wb_cp0_excode = '0;
        wbif.wb_cp0_badvaddr = '0; wbif.wb_cp0_bd = 1'b0; wbif.wb_cp0_we = 1'b0;
        wbif.wb_cp0_addr = '0; wbif.wb_cp0_wdata = '0; wbif.wb_cp0_eret_flush = 1'b0;
        ext_int = '0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        idle();
        wbif.wb_cp0_we = 1'b1; wbif.wb_cp0_addr = addr; wbif.wb_cp0_wdata = data;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input row_t r);
        wbif.wb_pc = r.pc; wbif.wb_cp0_ex = r.ex; wbif.wb_cp0_excode = r.exc;
        wbif.wb_cp0_badvaddr = r.badv; wbif.wb_cp0_bd = r.bd; wbif.wb_cp0_we = r.we;
        wbif.wb_cp0_addr = r.addr; wbif.wb_cp0_wdata = r.wd; wbif.wb_cp0_eret_flush = r.eret;
        ext_int = r.ext; cp0_raddr = r.ra;
    endtask

    initial begin
        //        ex exc bd pc            badv          we addr wd            er ext    ra   fl pc            rdata         has
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 11, 32'hFFFF_FFFF, 0, 6'h00, 12, 0, 32'h0,        32'h0040_0000, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 13, 0, 32'h0,        32'h0,         0));
        tbl.push_back(mk(1, 4, 1, 32'h8000_0104, 32'h1234_5671, 0, 0,  32'h0,        0, 6'h00, 14, 1, 32'hBFC0_0380, 32'h0,         0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 14, 0, 32'h8000_0100, 32'h8000_0100, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 8,  0, 32'h8000_0100, 32'h1234_5671, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 13, 0, 32'h8000_0100, 32'h8000_0010, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 12, 0, 32'h8000_0100, 32'h0040_0002, 0));
        tbl.push_back(mk(1, 8, 0, 32'h8000_0200, 32'hDEAD_BEEF, 0, 0,  32'h0,        0, 6'h00, 13, 1, 32'hBFC0_0380, 32'h8000_0010, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 14, 0, 32'h8000_0100, 32'h8000_0100, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 13, 0, 32'h8000_0100, 32'h8000_0020, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 8,  0, 32'h8000_0100, 32'h1234_5671, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        1, 6'h00, 12, 1, 32'h8000_0100, 32'h0040_0002, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 12, 0, 32'h8000_0100, 32'h0040_0000, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 12, 32'hFFFF_FFFF, 0, 6'h00, 12, 0, 32'h8000_0100, 32'h0040_0000, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 12, 0, 32'h8000_0100, 32'h0040_FF03, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 12, 32'h0000_8001, 0, 6'h00, 12, 0, 32'h8000_0100, 32'h0040_FF03, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h20, 12, 0, 32'h8000_0100, 32'h0040_8001, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 13, 0, 32'h8000_0100, 32'h8000_8020, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 13, 0, 32'h8000_0100, 32'h8000_0020, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 13, 32'hFFFF_FFFF, 0, 6'h00, 13, 0, 32'h8000_0100, 32'h8000_0020, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 13, 0, 32'h8000_0100, 32'h8000_0320, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 12, 32'h0000_0301, 0, 6'h00, 12, 0, 32'h8000_0100, 32'h0040_8001, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 12, 0, 32'h8000_0100, 32'h0040_0301, 1));
        tbl.push_back(mk(1, 12, 0, 32'h8000_0300, 32'h0,      1, 14, 32'h1111_1111, 0, 6'h00, 14, 1, 32'hBFC0_0380, 32'h8000_0100, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 14, 0, 32'h8000_0300, 32'h8000_0300, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 13, 0, 32'h8000_0300, 32'h0000_0330, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 14, 32'h2222_2222, 1, 6'h00, 12, 1, 32'h8000_0300, 32'h0040_0303, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 14, 0, 32'h8000_0300, 32'h8000_0300, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 3,  32'hFFFF_FFFF, 0, 6'h00, 3,  0, 32'h8000_0300, 32'h0,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 3,  0, 32'h8000_0300, 32'h0,         1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1, 14, 32'h8000_0400, 0, 6'h00, 14, 0, 32'h8000_0300, 32'h8000_0300, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 14, 0, 32'h8000_0400, 32'h8000_0400, 1));
        tbl.push_back(mk(1, 5, 0, 32'h8000_0500, 32'h0000_ABCD, 0, 0,  32'h0,        0, 6'h00, 8,  1, 32'hBFC0_0380, 32'h1234_5671, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        0, 6'h00, 8,  0, 32'h8000_0500, 32'h0000_ABCD, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0, 0,  32'h0,        1, 6'h00, 14, 1, 32'h8000_0500, 32'h8000_0500, 0));

        resetn = 1'b0;
        idle();
        cp0_raddr = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            #3;
            chk($sformatf("row%0d int_flush", i), {31'b0, int_flush}, {31'b0, tbl[i].e_flush});
            chk($sformatf("row%0d int_pc", i), int_pc, tbl[i].e_pc);
            chk($sformatf("row%0d cp0_rdata", i), cp0_rdata, tbl[i].e_rdata);
            chk($sformatf("row%0d has_int", i), {31'b0, has_int}, {31'b0, tbl[i].e_has});
            cyc();
        end

        // Reset asserted together with an exception commit: flush still follows, state stays reset.
        idle();
        resetn = 1'b0;
        wbif.wb_cp0_ex = 1'b1; wbif.wb_cp0_excode = 5'd4; wbif.wb_pc = 32'h8000_0600;
        wbif.wb_cp0_badvaddr = 32'h5555_0000;
        #3;
        chk("reset_flush", {31'b0, int_flush}, 32'd1);
        cyc();
        resetn = 1'b1;
        idle();
        cp0_raddr = 5'd12; #1; chk("reset_status", cp0_rdata, 32'h0040_0000);
        cp0_raddr = 5'd14; #1; chk("reset_epc", cp0_rdata, 32'h0);
        cp0_raddr = 5'd8;  #1; chk("reset_badvaddr", cp0_rdata, 32'h0);
        cp0_raddr = 5'd13; #1; chk("reset_cause", cp0_rdata, 32'h0);
        chk("reset_has_int", {31'b0, has_int}, 32'd0);
        chk("reset_int_pc", int_pc, 32'h0);

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd5);
        cyc();
        mtc0(5'd9, 32'd0);
        cyc();
        mtc0(5'd12, 32'h0000_8001);
        cp0_raddr = 5'd9; #1; chk("timer_count_load", cp0_rdata, 32'd0);
        cyc();
        idle();
        repeat (9) cyc();
        cp0_raddr = 5'd9;  #1; chk("timer_count_5", cp0_rdata, 32'd5);
        cp0_raddr = 5'd13; #1; chk("timer_ti_not_yet", {31'b0, cp0_rdata[30]}, 32'd0);
        chk("timer_has_int_0", {31'b0, has_int}, 32'd0);
        cyc();
        cp0_raddr = 5'd13; #1; chk("timer_ti_set", {31'b0, cp0_rdata[30]}, 32'd1);
        chk("timer_has_int_lag", {31'b0, has_int}, 32'd0);
        cyc();
        chk("timer_has_int_1", {31'b0, has_int}, 32'd1);
        mtc0(5'd11, 32'd100);
        cyc();
        idle();
        cp0_raddr = 5'd13; #1; chk("timer_ti_cleared", {31'b0, cp0_rdata[30]}, 32'd0);
        chk("timer_has_int_still", {31'b0, has_int}, 32'd1);
        cyc();
        chk("timer_has_int_cleared", {31'b0, has_int}, 32'd0);
        cp0_raddr = 5'd11; #1; chk("timer_compare", cp0_rdata, 32'd100);
`else
        mtc0(5'd9, 32'h0000_AAAA);
        cyc();
        mtc0(5'd12, 32'h0000_8001);
        cp0_raddr = 5'd9; #1; chk("notimer_count", cp0_rdata, 32'h0);
        cyc();
        mtc0(5'd11, 32'h0000_0003);
        cyc();
        idle();
        cp0_raddr = 5'd11; #1; chk("notimer_compare", cp0_rdata, 32'h0);
        cp0_raddr = 5'd12; #1; chk("notimer_status", cp0_rdata, 32'h0040_8001);
        for (int k = 0; k < 20; k++) begin
            cp0_raddr = 5'd13; #1;
            chk($sformatf("notimer_cause_%0d", k), cp0_rdata, 32'h0);
            chk($sformatf("notimer_has_int_%0d", k), {31'b0, has_int}, 32'd0);
            cyc();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
